// File: rtl/contador_sin_param_if.sv
// ============================================================================
// Module   : contador_sin_param_if
// Brief    : Control/status bundle for the contador_sin_param counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface contador_sin_param_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_gray;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  count, count_gray, tc, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output count, count_gray, tc, wrap
    );
endinterface

`default_nettype wire

// File: rtl/contador_sin_param.sv
// ============================================================================
// Module   : contador_sin_param
// Brief    : Modulo-N up/down counter with load, wrap/saturate, tc, Gray copy.
// Revision : 1.0
// ============================================================================
`default_nettype none

module contador_sin_param #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = 0
) (
    input  wire logic           clk,
    input  wire logic           rstn,
    contador_sin_param_if.slave bus
);
    localparam logic [WIDTH:0] c_max = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] c_one = (WIDTH+1)'(1);
    localparam bit             c_sat = (SATURATE != 0);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH:0]   w_cur;
    logic [WIDTH:0]   w_load;
    logic [WIDTH:0]   w_next;
    logic             w_wrap_next;
    logic             w_at_max;
    logic             w_at_zero;

    // One extra bit keeps the +1 at the top code from aliasing back to zero
    assign w_cur     = {1'b0, r_count};
    assign w_load    = {1'b0, bus.load_val};
    assign w_at_max  = (w_cur == c_max);
    assign w_at_zero = (w_cur == '0);

    always_comb begin
        w_next      = w_cur;
        w_wrap_next = 1'b0;
        if (bus.load) begin
            w_next = (w_load > c_max) ? c_max : w_load;
        end else if (bus.en) begin
            if (bus.up) begin
                if (!w_at_max) begin
                    w_next = w_cur + c_one;
                end else if (!c_sat) begin
                    w_next      = '0;
                    w_wrap_next = 1'b1;
                end
            end else begin
                if (!w_at_zero) begin
                    w_next = w_cur - c_one;
                end else if (!c_sat) begin
                    w_next      = c_max;
                    w_wrap_next = 1'b1;
                end
            end
        end
    end

    // Gray is taken from the next value so it lands in the same cycle as count;
    // bit WIDTH of w_next is always zero, which makes this next ^ (next >> 1)
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_count <= '0;
            r_gray  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next[WIDTH-1:0];
            r_gray  <= w_next[WIDTH-1:0] ^ w_next[WIDTH:1];
            r_wrap  <= w_wrap_next;
        end
    end

    assign bus.count      = r_count;
    assign bus.count_gray = r_gray;
    assign bus.wrap       = r_wrap;
    assign bus.tc         = bus.en & ((bus.up & w_at_max) | (~bus.up & w_at_zero));

endmodule

`default_nettype wire

// File: tb/tb_contador_sin_param.sv
// ============================================================================
// Module   : tb_contador_sin_param
// Brief    : Directed self-checking bench for contador_sin_param (3 configs).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_contador_sin_param;
    logic clk = 1'b0;
    logic rstn;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    contador_sin_param_if #(.WIDTH(3)) ia ();
    contador_sin_param_if #(.WIDTH(3)) ib ();
    contador_sin_param_if #(.WIDTH(3)) ic ();

    // a: mod-6 wrap, b: mod-6 saturate, c: full-range mod-8 wrap
    contador_sin_param #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_a (.clk(clk), .rstn(rstn), .bus(ia));
    contador_sin_param #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) u_b (.clk(clk), .rstn(rstn), .bus(ib));
    contador_sin_param #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_c (.clk(clk), .rstn(rstn), .bus(ic));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // count, gray, wrap, tc of instance a
    task automatic chk_a(input string tag, input int c, input int g, input int w, input int t);
        chk({tag, ".count"}, 32'(ia.count), 32'(c));
        chk({tag, ".gray"},  32'(ia.count_gray), 32'(g));
        chk({tag, ".wrap"},  32'(ia.wrap), 32'(w));
        chk({tag, ".tc"},    32'(ia.tc), 32'(t));
    endtask

    int up_cnt  [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    int up_gray [8] = '{1, 3, 2, 6, 7, 0, 1, 3};
    int up_wrap [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int up_tc   [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int c_en    [6] = '{0, 1, 0, 1, 0, 1};
    int c_cnt   [6] = '{6, 7, 7, 0, 0, 1};
    int c_gray  [6] = '{5, 4, 4, 0, 0, 1};
    int c_wrap  [6] = '{0, 0, 0, 1, 0, 0};

    initial begin
        rstn = 1'b1;
        ia.en = 1'b1; ia.up = 1'b1; ia.load = 1'b1; ia.load_val = 3'd5;
        ib.en = 1'b0; ib.up = 1'b1; ib.load = 1'b0; ib.load_val = 3'd0;
        ic.en = 1'b0; ic.up = 1'b1; ic.load = 1'b0; ic.load_val = 3'd0;

        // reset wins over load and en
        for (int i = 0; i < 2; i++) begin
            step();
            chk_a("rst", 0, 0, 0, 0);
        end
        ia.up = 1'b0;
        #1 chk("rst.tc_down", 32'(ia.tc), 32'd1);
        chk("rst.b_count", 32'(ib.count), 32'd0);

        rstn = 1'b0; ia.load = 1'b0; ia.up = 1'b1;
        step(); chk_a("post_rst1", 1, 1, 0, 0);
        step(); chk_a("post_rst2", 2, 3, 0, 0);
        step(); chk_a("post_rst3", 3, 2, 0, 0);

        // up-wrap from 0
        ia.load = 1'b1; ia.load_val = 3'd0;
        step(); ia.load = 1'b0;
        #1 chk_a("upwrap.start", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk_a($sformatf("upwrap%0d", i), up_cnt[i], up_gray[i], up_wrap[i], up_tc[i]);
        end

        // down-wrap and direction change
        ia.up = 1'b0;
        step(); chk_a("down.to1", 1, 1, 0, 0);
        step(); chk_a("down.to0", 0, 0, 0, 1);
        step(); chk_a("down.to5", 5, 7, 1, 0);
        step(); chk_a("down.to4", 4, 6, 0, 0);
        ia.up = 1'b1;
        step(); chk_a("dirchg.to5", 5, 7, 0, 1);

        // load, clamp, load beats terminal wrap
        ia.en = 1'b0; ia.load = 1'b1; ia.load_val = 3'd3;
        step(); chk_a("load3", 3, 2, 0, 0);
        ia.load_val = 3'd7;
        step(); chk_a("load_clamp", 5, 7, 0, 0);
        ia.en = 1'b1; ia.up = 1'b1; ia.load_val = 3'd2;
        step(); chk_a("load_vs_tc", 2, 3, 0, 0);
        ia.load = 1'b0; ia.en = 1'b0;
        step(); chk_a("hold", 2, 3, 0, 0);

        // saturate instance
        ib.load = 1'b1; ib.load_val = 3'd4;
        step(); ib.load = 1'b0; ib.en = 1'b1; ib.up = 1'b1;
        #1 chk("sat.load4", 32'(ib.count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("sat_up%0d.count", i), 32'(ib.count), 32'd5);
            chk($sformatf("sat_up%0d.gray", i), 32'(ib.count_gray), 32'd7);
            chk($sformatf("sat_up%0d.tc", i), 32'(ib.tc), 32'd1);
            chk($sformatf("sat_up%0d.wrap", i), 32'(ib.wrap), 32'd0);
        end
        ib.load = 1'b1; ib.load_val = 3'd0;
        step(); ib.load = 1'b0; ib.up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("sat_dn%0d.count", i), 32'(ib.count), 32'd0);
            chk($sformatf("sat_dn%0d.tc", i), 32'(ib.tc), 32'd1);
            chk($sformatf("sat_dn%0d.wrap", i), 32'(ib.wrap), 32'd0);
        end

        // full-range instance, en toggled
        ic.load = 1'b1; ic.load_val = 3'd6;
        step(); ic.load = 1'b0; ic.up = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ic.en = c_en[i][0];
            step();
            chk($sformatf("full%0d.count", i), 32'(ic.count), 32'(c_cnt[i]));
            chk($sformatf("full%0d.gray", i), 32'(ic.count_gray), 32'(c_gray[i]));
            chk($sformatf("full%0d.wrap", i), 32'(ic.wrap), 32'(c_wrap[i]));
        end

        // reset mid-sequence
        rstn = 1'b1;
        step();
        chk("midrst.c", 32'(ic.count), 32'd0);
        chk("midrst.a", 32'(ia.count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/contador_sin_param.md
# contador_sin_param

Parametrised synchronous modulo-N up/down counter, the general successor to the fixed 3-bit synchronous counter. It adds width/modulus parameters, direction control, count enable, parallel load, a wrap-or-saturate mode, a terminal-count flag, a registered wrap pulse and a Gray-coded copy of the count. It is the counter/prescaler primitive for timers and sequencers in the design.

## Interface
Parameters:
- WIDTH, 3: counter width in bits; must be ≥ 1.
- MODULUS, 8: count range is 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- SATURATE, 0: 0 = wrap at range ends; 1 = hold at range ends.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rstn, input, 1: synchronous, active-high reset.
  - Despite the codebase name, 1 = reset, sampled on the rising edge of clk.
- en, input, 1: count enable.
- up, input, 1: direction, 1 = increment, 0 = decrement.
- load, input, 1: parallel load strobe.
- load_val, input, WIDTH: value to load.
- count, output, WIDTH: registered binary count.
- count_gray, output, WIDTH: registered Gray code of count, equal to count ^ (count >> 1).
- tc, output, 1: combinational terminal-count flag.
- wrap, output, 1: registered one-cycle pulse, set in the cycle after a wrap occurred.

## Operation
- Update priority each rising edge, highest first: rstn, then load, then en, then hold.
- rstn = 1:
  - count = 0, count_gray = 0, wrap = 0.
  - Applies regardless of load/en and mid-sequence.
  - The first edge with rstn = 0 resumes normal operation from 0.
- load = 1 (rstn = 0):
  - count ← load_val when load_val < MODULUS; otherwise count ← MODULUS-1 (clamp).
  - en and up are ignored that cycle; wrap ← 0.
- en = 1, up = 1:
  - count < MODULUS-1: count ← count+1.
  - count = MODULUS-1 with SATURATE = 0: count ← 0, wrap ← 1.
  - count = MODULUS-1 with SATURATE = 1: count holds, wrap ← 0.
- en = 1, up = 0:
  - count > 0: count ← count-1.
  - count = 0 with SATURATE = 0: count ← MODULUS-1, wrap ← 1.
  - count = 0 with SATURATE = 1: count holds, wrap ← 0.
- en = 0 and no load: count holds, wrap ← 0.
- wrap is 1 only in the single cycle following a rollover edge. It is never asserted in saturate mode.
- tc = en & ((up & count = MODULUS-1) | (~up & count = 0)).
  - tc is purely combinational from the current inputs and state.
  - tc is asserted during a saturated hold too.
- Arithmetic:
  - Next-state computation uses WIDTH+1 bits internally, so the +1 at count = 2^WIDTH-1 cannot alias.
  - count never leaves 0..MODULUS-1 after reset.
- count_gray is registered from the next-state binary value, so it is always coherent with count in the same cycle.
- Changing direction takes effect on the same edge it is sampled; there is no pipeline.
- When MODULUS = 2^WIDTH, behaviour is the natural binary roll.

## Timing
- Latency from en/up/load/load_val at edge k to count, count_gray and wrap is 1 cycle: valid after edge k.
- tc has zero latency: it follows en/up combinationally within the cycle.
- There is no handshake. en may be held high indefinitely for one step per cycle.
- Reset behaviour:
  - Reset takes effect at the first edge with rstn = 1.
  - Outputs are undefined only before that first edge.
  - During reset, tc reflects en/up against count = 0, so tc = en & ~up.
- Simultaneous events:
  - load together with a terminal condition: load wins, no wrap.
  - rstn together with load: reset wins.

## Test plan
- Reset: WIDTH = 3, MODULUS = 6, hold rstn = 1 for 2 edges with en = 1, load = 1, load_val = 5 → count = 0, count_gray = 0, wrap = 0. Release and run en = 1, up = 1 → count 1, 2, 3.
- Up-wrap: MODULUS = 6, SATURATE = 0, en = 1, up = 1 from 0 for 8 edges → count 1, 2, 3, 4, 5, 0, 1, 2.
  - tc = 1 while count = 5.
  - wrap = 1 only in the cycle after the 5→0 edge.
  - count_gray tracks, e.g. 5 → 3'b111, 4 → 3'b110.
- Down-wrap and direction change: from count = 1, up = 0 for 3 edges → 0, 5, 4, with wrap after 0→5. Then up = 1 for 1 edge → 5.
- Saturate: SATURATE = 1, MODULUS = 6, up = 1 from 4 for 4 edges → 5, 5, 5, 5 with tc = 1 and wrap = 0 throughout. Then up = 0 from 0 → holds at 0.
- Load: load_val = 3 → count = 3. load_val = 7 (≥ MODULUS) → count = 5. load = 1 with en = 1, up = 1 at count = 5 → count = load_val, wrap = 0.
- Full-range mode: WIDTH = 3, MODULUS = 8, en toggled every other cycle from 6 → 6, 7, 7, 0 (with wrap), 0, 1. Holds are verified on en = 0 cycles.
